// File: rtl/src_ctrl_pkg.sv
// Shared definitions for the Mini-SRC hardwired control sequencer: state
// encoding, IR field layout, opcode values and alu_ctrl bit positions.
package src_ctrl_pkg;

  localparam int unsigned IrW   = 32;
  localparam int unsigned OPW   = 5;   // opcode field IR[31:27]
  localparam int unsigned REGW  = 4;   // Ra, Rb, Rc fields below the opcode
  localparam int unsigned OpLsb = IrW - OPW;
  localparam int unsigned AluW  = 10;

  typedef enum logic [2:0] {
    StRst  = 3'd0,
    StT0   = 3'd1,
    StT1   = 3'd2,
    StT2   = 3'd3,
    StT3   = 3'd4,
    StT4   = 3'd5,
    StT5   = 3'd6,
    StHalt = 3'd7
  } state_e;

  localparam logic [OPW-1:0] OpAdd  = 5'b00011;
  localparam logic [OPW-1:0] OpSub  = 5'b00100;
  localparam logic [OPW-1:0] OpAnd  = 5'b00101;
  localparam logic [OPW-1:0] OpOr   = 5'b00110;
  localparam logic [OPW-1:0] OpShr  = 5'b00111;
  localparam logic [OPW-1:0] OpShl  = 5'b01000;
  localparam logic [OPW-1:0] OpRor  = 5'b01001;
  localparam logic [OPW-1:0] OpRol  = 5'b01010;
  localparam logic [OPW-1:0] OpNeg  = 5'b10000;
  localparam logic [OPW-1:0] OpNot  = 5'b10001;
  localparam logic [OPW-1:0] OpNop  = 5'b11010;
  localparam logic [OPW-1:0] OpHalt = 5'b11011;

  localparam int unsigned AluAdd = 0;
  localparam int unsigned AluSub = 1;
  localparam int unsigned AluAnd = 2;
  localparam int unsigned AluOr  = 3;
  localparam int unsigned AluShr = 4;
  localparam int unsigned AluShl = 5;
  localparam int unsigned AluRor = 6;
  localparam int unsigned AluRol = 7;
  localparam int unsigned AluNeg = 8;
  localparam int unsigned AluNot = 9;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode decoder.
//   opcode_i     : IR opcode field
//   alu_ctrl_o   : one-hot ALU function select, zero for non-ALU opcodes
//   is_alu_o     : opcode is one of the ten ALU operations
//   is_unary_o   : neg/not (single source operand taken from Rb)
//   is_nop_o     : nop
//   is_halt_o    : halt
//   is_illegal_o : opcode not in the instruction set
module opcode_decoder
  import src_ctrl_pkg::*;
(
  input  logic [OPW-1:0]  opcode_i,
  output logic [AluW-1:0] alu_ctrl_o,
  output logic            is_alu_o,
  output logic            is_unary_o,
  output logic            is_nop_o,
  output logic            is_halt_o,
  output logic            is_illegal_o
);

  always_comb begin
    alu_ctrl_o   = '0;
    is_unary_o   = 1'b0;
    is_nop_o     = 1'b0;
    is_halt_o    = 1'b0;
    is_illegal_o = 1'b0;
    unique case (opcode_i)
      OpAdd:   alu_ctrl_o[AluAdd] = 1'b1;
      OpSub:   alu_ctrl_o[AluSub] = 1'b1;
      OpAnd:   alu_ctrl_o[AluAnd] = 1'b1;
      OpOr:    alu_ctrl_o[AluOr]  = 1'b1;
      OpShr:   alu_ctrl_o[AluShr] = 1'b1;
      OpShl:   alu_ctrl_o[AluShl] = 1'b1;
      OpRor:   alu_ctrl_o[AluRor] = 1'b1;
      OpRol:   alu_ctrl_o[AluRol] = 1'b1;
      OpNeg: begin
        alu_ctrl_o[AluNeg] = 1'b1;
        is_unary_o         = 1'b1;
      end
      OpNot: begin
        alu_ctrl_o[AluNot] = 1'b1;
        is_unary_o         = 1'b1;
      end
      OpNop:   is_nop_o     = 1'b1;
      OpHalt:  is_halt_o    = 1'b1;
      default: is_illegal_o = 1'b1;
    endcase
  end

  assign is_alu_o = |alu_ctrl_o;

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit for the Mini-SRC datapath. Fetches (T0-T2) and
// executes register-register ALU instructions (T3-T5), with memory wait in T1
// and a sticky HALT state left only through clear.
//   clock, clear            : clock and asynchronous active-high reset
//   ir                      : datapath IR contents (decoded in T3-T5)
//   mem_ready, stop         : memory read done (T1), halt request (T0)
//   PCout..Rout             : Moore bus/register/memory strobes
//   alu_ctrl                : one-hot ALU function, only in T4
//   run, illegal_op         : sequencing flag, registered bad-opcode pulse
module control_sequencer
  import src_ctrl_pkg::*;
(
  input  logic            clock,
  input  logic            clear,
  input  logic [IrW-1:0]  ir,
  input  logic            mem_ready,
  input  logic            stop,
  output logic            PCout,
  output logic            Zlowout,
  output logic            MDRout,
  output logic            MARin,
  output logic            PCin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            Zin,
  output logic            IncPC,
  output logic            Read,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic [AluW-1:0] alu_ctrl,
  output logic            run,
  output logic            illegal_op
);

  state_e          state_q, state_d;
  logic            illegal_op_q, illegal_op_d;
  logic [AluW-1:0] dec_alu;
  logic            dec_is_alu, dec_is_unary, dec_is_nop, dec_is_halt, dec_is_illegal;

  // Register fields are consumed by the datapath's select/encode logic via Gra/Grb/Grc.
  logic unused_ir;
  assign unused_ir = ^{ir[OpLsb-1 -: 3*REGW], ir[OpLsb-3*REGW-1:0], dec_is_nop};

  opcode_decoder u_opcode_decoder (
    .opcode_i     (ir[IrW-1:OpLsb]),
    .alu_ctrl_o   (dec_alu),
    .is_alu_o     (dec_is_alu),
    .is_unary_o   (dec_is_unary),
    .is_nop_o     (dec_is_nop),
    .is_halt_o    (dec_is_halt),
    .is_illegal_o (dec_is_illegal)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q      <= StRst;
      illegal_op_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      illegal_op_q <= illegal_op_d;
    end
  end

  // The opcode is judged in T3: IR only holds the new instruction after the T2 edge.
  assign illegal_op_d = (state_q == StT3) && dec_is_illegal;
  assign illegal_op   = illegal_op_q;

  always_comb begin
    state_d  = state_q;
    PCout    = 1'b0;
    Zlowout  = 1'b0;
    MDRout   = 1'b0;
    MARin    = 1'b0;
    PCin     = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    Gra      = 1'b0;
    Grb      = 1'b0;
    Grc      = 1'b0;
    Rin      = 1'b0;
    Rout     = 1'b0;
    alu_ctrl = '0;
    run      = 1'b1;
    unique case (state_q)
      StRst: begin
        run     = 1'b0;
        state_d = StT0;
      end
      StT0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        Zin     = 1'b1;
        state_d = stop ? StHalt : StT1;
      end
      StT1: begin
        // Held through wait cycles; reloading PC from the same Z is harmless.
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        state_d = mem_ready ? StT2 : StT1;
      end
      StT2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = StT3;
      end
      StT3: begin
        if (dec_is_alu) begin
          Grb     = 1'b1;
          Rout    = 1'b1;
          Yin     = 1'b1;
          state_d = StT4;
        end else if (dec_is_halt) begin
          state_d = StHalt;
        end else begin
          state_d = StT0;
        end
      end
      StT4: begin
        Grb      = dec_is_unary;
        Grc      = ~dec_is_unary;
        Rout     = 1'b1;
        Zin      = 1'b1;
        alu_ctrl = dec_alu;
        state_d  = StT5;
      end
      StT5: begin
        Zlowout = 1'b1;
        Gra     = 1'b1;
        Rin     = 1'b1;
        state_d = StT0;
      end
      StHalt: begin
        run     = 1'b0;
        state_d = StHalt;
      end
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [31:0] ir = '0;
  logic        mem_ready = 1'b0;
  logic        stop = 1'b0;
  logic        PCout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin, IncPC, Read;
  logic        Gra, Grb, Grc, Rin, Rout, run, illegal_op;
  logic [9:0]  alu_ctrl;

  control_sequencer dut (
    .clock      (clock),
    .clear      (clear),
    .ir         (ir),
    .mem_ready  (mem_ready),
    .stop       (stop),
    .PCout      (PCout),
    .Zlowout    (Zlowout),
    .MDRout     (MDRout),
    .MARin      (MARin),
    .PCin       (PCin),
    .MDRin      (MDRin),
    .IRin       (IRin),
    .Yin        (Yin),
    .Zin        (Zin),
    .IncPC      (IncPC),
    .Read       (Read),
    .Gra        (Gra),
    .Grb        (Grb),
    .Grc        (Grc),
    .Rin        (Rin),
    .Rout       (Rout),
    .alu_ctrl   (alu_ctrl),
    .run        (run),
    .illegal_op (illegal_op)
  );

  always #5 clock = ~clock;

  // Observation word: 18 single-bit controls followed by alu_ctrl.
  logic [27:0] obs;
  assign obs = {PCout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin, IncPC, Read,
                Gra, Grb, Grc, Rin, Rout, run, illegal_op, alu_ctrl};

  localparam logic [17:0] M_PCOUT = 18'd1 << 17;
  localparam logic [17:0] M_ZLOW  = 18'd1 << 16;
  localparam logic [17:0] M_MDROUT = 18'd1 << 15;
  localparam logic [17:0] M_MARIN = 18'd1 << 14;
  localparam logic [17:0] M_PCIN  = 18'd1 << 13;
  localparam logic [17:0] M_MDRIN = 18'd1 << 12;
  localparam logic [17:0] M_IRIN  = 18'd1 << 11;
  localparam logic [17:0] M_YIN   = 18'd1 << 10;
  localparam logic [17:0] M_ZIN   = 18'd1 << 9;
  localparam logic [17:0] M_INCPC = 18'd1 << 8;
  localparam logic [17:0] M_READ  = 18'd1 << 7;
  localparam logic [17:0] M_GRA   = 18'd1 << 6;
  localparam logic [17:0] M_GRB   = 18'd1 << 5;
  localparam logic [17:0] M_GRC   = 18'd1 << 4;
  localparam logic [17:0] M_RIN   = 18'd1 << 3;
  localparam logic [17:0] M_ROUT  = 18'd1 << 2;
  localparam logic [17:0] M_RUN   = 18'd1 << 1;
  localparam logic [17:0] M_ILL   = 18'd1;

  localparam logic [17:0] E_T0  = M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN;
  localparam logic [17:0] E_T1  = M_ZLOW | M_PCIN | M_READ | M_MDRIN | M_RUN;
  localparam logic [17:0] E_T2  = M_MDROUT | M_IRIN | M_RUN;
  localparam logic [17:0] E_T3A = M_GRB | M_ROUT | M_YIN | M_RUN;
  localparam logic [17:0] E_T3N = M_RUN;
  localparam logic [17:0] E_T4B = M_GRC | M_ROUT | M_ZIN | M_RUN;
  localparam logic [17:0] E_T4U = M_GRB | M_ROUT | M_ZIN | M_RUN;
  localparam logic [17:0] E_T5  = M_ZLOW | M_GRA | M_RIN | M_RUN;

  localparam logic [31:0] IR_AND  = 32'h2800_0000;
  localparam logic [31:0] IR_NEG  = {5'b10000, 27'h0};
  localparam logic [31:0] IR_NOP  = {5'b11010, 27'h0};
  localparam logic [31:0] IR_BAD  = {5'b11111, 27'h0};
  localparam logic [31:0] IR_HALT = {5'b11011, 27'h0};

  typedef struct {
    logic        clr;
    logic [31:0] ir;
    logic        mr;
    logic        stp;
    logic [27:0] exp;
    string       name;
  } vec_t;

  typedef struct {
    logic [27:0] exp;
    string       name;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [27:0] o(input logic [17:0] c, input logic [9:0] a);
    return {c, a};
  endfunction

  task automatic add(input logic clr, input logic [31:0] ir_v, input logic mr, input logic stp,
                     input logic [27:0] exp, input string name);
    vec_t v;
    v.clr = clr; v.ir = ir_v; v.mr = mr; v.stp = stp; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic check_now(input logic [27:0] exp, input string name);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %07h expected %07h", name, obs, exp);
    end
  endtask

  // Scoreboard side: each queued expectation is compared mid-cycle.
  always @(negedge clock) begin
    if (sb_q.size() > 0) begin
      sb_t e;
      e = sb_q.pop_front();
      check_now(e.exp, e.name);
    end
  end

  // Fetch-through-execute of a two-operand or unary ALU op with a given wait count.
  task automatic add_alu(input logic [31:0] ir_v, input int waits, input logic [17:0] t4,
                         input logic [9:0] alu, input string tag);
    add(0, ir_v, 0, 0, o(E_T0, '0), {tag, "_t0"});
    for (int i = 0; i < waits; i++) add(0, ir_v, 0, 0, o(E_T1, '0), {tag, "_t1_wait"});
    add(0, ir_v, 1, 0, o(E_T1, '0), {tag, "_t1"});
    add(0, ir_v, 0, 0, o(E_T2, '0), {tag, "_t2"});
    add(0, ir_v, 0, 0, o(E_T3A, '0), {tag, "_t3"});
    add(0, ir_v, 0, 0, o(t4, alu), {tag, "_t4"});
    add(0, ir_v, 0, 0, o(E_T5, '0), {tag, "_t5"});
  endtask

  initial begin
    // Reset, then a plain "and" fetch/execute.
    add(1, '0, 0, 0, '0, "rst_hold");
    add(0, '0, 0, 0, '0, "rst_idle");
    add_alu(IR_AND, 0, E_T4B, 10'h004, "and");
    // Three wait cycles in T1.
    add_alu(IR_AND, 3, E_T4B, 10'h004, "and_wait");
    // Unary neg uses Rb as the ALU operand in T4.
    add_alu(IR_NEG, 0, E_T4U, 10'h100, "neg");
    // nop: no strobes in T3, straight back to fetch.
    add(0, IR_NOP, 0, 0, o(E_T0, '0), "nop_t0");
    add(0, IR_NOP, 1, 0, o(E_T1, '0), "nop_t1");
    add(0, IR_NOP, 0, 0, o(E_T2, '0), "nop_t2");
    add(0, IR_NOP, 0, 0, o(E_T3N, '0), "nop_t3");
    // Illegal opcode: same path plus one-cycle illegal_op in the following T0.
    add(0, IR_BAD, 0, 0, o(E_T0, '0), "bad_t0");
    add(0, IR_BAD, 1, 0, o(E_T1, '0), "bad_t1");
    add(0, IR_BAD, 0, 0, o(E_T2, '0), "bad_t2");
    add(0, IR_BAD, 0, 0, o(E_T3N, '0), "bad_t3");
    add(0, IR_HALT, 0, 0, o(E_T0 | M_ILL, '0), "bad_pulse_t0");
    add(0, IR_HALT, 1, 0, o(E_T1, '0), "bad_pulse_gone");
    // Halt opcode.
    add(0, IR_HALT, 0, 0, o(E_T2, '0), "halt_t2");
    add(0, IR_HALT, 0, 0, o(E_T3N, '0), "halt_t3");
    for (int i = 0; i < 10; i++) add(0, IR_HALT, 1, 1, '0, "halt_op_hold");
    add(1, IR_HALT, 0, 0, '0, "halt_op_clear");
    add(0, IR_AND, 0, 0, '0, "halt_op_rst");
    // stop sampled in T0.
    add(0, IR_AND, 1, 1, o(E_T0, '0), "stop_t0");
    for (int i = 0; i < 10; i++) add(0, IR_AND, 1, 0, '0, "stop_hold");
    add(1, IR_AND, 0, 0, '0, "stop_clear");
    add(0, IR_AND, 0, 0, '0, "stop_rst");

    @(posedge clock);
    for (int i = 0; i < vecs.size(); i++) begin
      sb_t e;
      if (i > 0) @(posedge clock);
      #1;
      clear     = vecs[i].clr;
      ir        = vecs[i].ir;
      mem_ready = vecs[i].mr;
      stop      = vecs[i].stp;
      e.exp  = vecs[i].exp;
      e.name = vecs[i].name;
      sb_q.push_back(e);
    end
    @(negedge clock);
    #1;

    // Asynchronous clear in the middle of T4.
    ir = IR_AND; mem_ready = 1'b1; stop = 1'b0;
    @(posedge clock); #1 check_now(o(E_T0, '0), "async_t0");
    @(posedge clock); #1 check_now(o(E_T1, '0), "async_t1");
    @(posedge clock); #1 check_now(o(E_T2, '0), "async_t2");
    @(posedge clock); #1 check_now(o(E_T3A, '0), "async_t3");
    @(posedge clock); #1 check_now(o(E_T4B, 10'h004), "async_t4");
    #2 clear = 1'b1;
    #1 check_now('0, "async_clear_immediate");
    @(posedge clock); #1 clear = 1'b0;
    check_now('0, "async_rst_state");
    @(posedge clock); #1 check_now(o(E_T0, '0), "async_release_t0");

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
